// File: rtl/openofdm_tx_sched.sv
// -----------------------------------------------------------------------------
// openofdm_tx_sched
// Transmit scheduler in front of the OpenOFDM TX core. Up to four requesters
// raise level-held requests; the scheduler grants one at a time round-robin,
// kicks the core with a start pulse, supervises the started/done handshake
// with timeouts, resets the core after a timeout and enforces an idle gap
// between packets. It also supplies a fresh data-scrambler seed per packet
// and keeps packet/error counters.
//
// Ports
//   clk                    : 100 MHz clock, rising edge
//   phy_tx_rst             : synchronous active-high reset
//   sched_en               : scheduler enable (blocks new grants only)
//   gap_cycles[15:0]       : idle cycles inserted after each packet/recovery
//   tx_req[3:0]            : per-requester request, level-held
//   tx_grant[3:0]          : one-hot grant, held for the whole packet
//   tx_ack[3:0]            : one-cycle completion pulse on the granted bit
//   tx_err                 : one-cycle pulse when a timeout fires
//   phy_tx_start           : one-cycle start pulse to the TX core
//   phy_tx_started         : core reports TX has begun
//   phy_tx_done            : core reports end of packet
//   core_rst               : reset pulse to the TX core after a timeout
//   init_data_scram_state  : per-packet scrambler seed (never zero)
//   pkt_cnt[15:0]          : completed packets, wraps
//   err_cnt[7:0]           : timeouts, saturates at 0xFF
// -----------------------------------------------------------------------------
module openofdm_tx_sched #(
    parameter int START_TIMEOUT = 200,
    parameter int DONE_TIMEOUT  = 400000,
    parameter int RST_CYCLES    = 8
) (
    input  logic        clk,
    input  logic        phy_tx_rst,
    input  logic        sched_en,
    input  logic [15:0] gap_cycles,
    input  logic [3:0]  tx_req,
    output logic [3:0]  tx_grant,
    output logic [3:0]  tx_ack,
    output logic        tx_err,
    output logic        phy_tx_start,
    input  logic        phy_tx_started,
    input  logic        phy_tx_done,
    output logic        core_rst,
    output logic [6:0]  init_data_scram_state,
    output logic [15:0] pkt_cnt,
    output logic [7:0]  err_cnt
);

    typedef enum logic [2:0] {
        IDLE,
        WAIT_STARTED,
        WAIT_DONE,
        RECOVER,
        GAP
    } state_t;

    // The timer is compared against the last cycle of each window so that a
    // window of N cycles ends when the timer reads N-1.
    localparam logic [31:0] START_LAST = START_TIMEOUT - 1;
    localparam logic [31:0] DONE_LAST  = DONE_TIMEOUT - 1;
    localparam logic [31:0] RST_LAST   = RST_CYCLES - 1;

    state_t      r_state;
    logic [3:0]  r_grant;
    logic [3:0]  r_ack;
    logic        r_err;
    logic        r_start;
    logic        r_core_rst;
    logic [6:0]  r_seed;
    logic [15:0] r_pkt_cnt;
    logic [7:0]  r_err_cnt;
    logic [1:0]  r_rr_ptr;
    logic [31:0] r_timer;
    logic [15:0] r_gap_len;

    state_t      w_state_nx;
    logic [3:0]  w_grant_nx;
    logic [3:0]  w_ack_nx;
    logic        w_err_nx;
    logic        w_start_nx;
    logic        w_core_rst_nx;
    logic [6:0]  w_seed_nx;
    logic [15:0] w_pkt_cnt_nx;
    logic [7:0]  w_err_cnt_nx;
    logic [1:0]  w_rr_ptr_nx;
    logic [31:0] w_timer_nx;
    logic [15:0] w_gap_len_nx;

    logic        w_found;
    logic [1:0]  w_sel_idx;
    logic        w_complete;
    logic        w_timeout;
    logic        w_leave;
    logic [31:0] w_gap_last;

    assign w_gap_last = {16'd0, r_gap_len - 16'd1};

    // Round-robin search starting at r_rr_ptr. The loop runs from the
    // farthest offset down so the nearest requesting index is written last
    // and therefore wins.
    always_comb begin
        w_found   = 1'b0;
        w_sel_idx = r_rr_ptr;
        for (int i = 3; i >= 0; i--) begin
            if (tx_req[r_rr_ptr + 2'(i)]) begin
                w_found   = 1'b1;
                w_sel_idx = r_rr_ptr + 2'(i);
            end
        end
    end

    // Next-state and next-output logic. Completion and timeout are flagged
    // per state and then applied in one place so that every path that ends
    // a packet behaves identically. Completion is checked before timeout,
    // which gives phy_tx_done priority over an expiring timer.
    always_comb begin
        w_state_nx    = r_state;
        w_grant_nx    = r_grant;
        w_ack_nx      = 4'b0000;
        w_err_nx      = 1'b0;
        w_start_nx    = 1'b0;
        w_core_rst_nx = 1'b0;
        w_seed_nx     = r_seed;
        w_pkt_cnt_nx  = r_pkt_cnt;
        w_err_cnt_nx  = r_err_cnt;
        w_rr_ptr_nx   = r_rr_ptr;
        w_timer_nx    = r_timer + 32'd1;
        w_gap_len_nx  = r_gap_len;
        w_complete    = 1'b0;
        w_timeout     = 1'b0;
        w_leave       = 1'b0;

        case (r_state)
            IDLE: begin
                w_timer_nx = 32'd0;
                if (sched_en && w_found) begin
                    w_grant_nx  = 4'b0001 << w_sel_idx;
                    w_start_nx  = 1'b1;
                    w_rr_ptr_nx = w_sel_idx + 2'd1;
                    w_state_nx  = WAIT_STARTED;
                end
            end
            WAIT_STARTED: begin
                if (phy_tx_started && phy_tx_done) begin
                    w_complete = 1'b1;
                end else if (phy_tx_started) begin
                    w_state_nx = WAIT_DONE;
                    w_timer_nx = 32'd0;
                end else if (r_timer == START_LAST) begin
                    w_timeout = 1'b1;
                end
            end
            WAIT_DONE: begin
                if (phy_tx_done) begin
                    w_complete = 1'b1;
                end else if (r_timer == DONE_LAST) begin
                    w_timeout = 1'b1;
                end
            end
            RECOVER: begin
                if (r_timer == RST_LAST) begin
                    w_leave = 1'b1;
                end else begin
                    w_core_rst_nx = 1'b1;
                end
            end
            GAP: begin
                if (r_timer == w_gap_last) begin
                    w_state_nx = IDLE;
                    w_timer_nx = 32'd0;
                end
            end
            default: begin
                w_state_nx = IDLE;
                w_grant_nx = 4'b0000;
            end
        endcase

        if (w_complete) begin
            w_ack_nx     = r_grant;
            w_pkt_cnt_nx = r_pkt_cnt + 16'd1;
            w_seed_nx    = {r_seed[5:0], r_seed[6] ^ r_seed[3]};
            w_grant_nx   = 4'b0000;
            w_leave      = 1'b1;
        end

        if (w_timeout) begin
            w_err_nx      = 1'b1;
            w_err_cnt_nx  = (r_err_cnt == 8'hFF) ? r_err_cnt : r_err_cnt + 8'd1;
            w_grant_nx    = 4'b0000;
            w_core_rst_nx = 1'b1;
            w_state_nx    = RECOVER;
            w_timer_nx    = 32'd0;
        end

        // The gap length is latched here so a config change mid-gap has no
        // effect on the gap already running.
        if (w_leave) begin
            w_timer_nx   = 32'd0;
            w_gap_len_nx = gap_cycles;
            w_state_nx   = (gap_cycles == 16'd0) ? IDLE : GAP;
        end
    end

    // State register with synchronous reset; reset abandons any packet in
    // flight without producing an ack or error pulse.
    always_ff @(posedge clk) begin
        if (phy_tx_rst) begin
            r_state    <= IDLE;
            r_grant    <= 4'b0000;
            r_ack      <= 4'b0000;
            r_err      <= 1'b0;
            r_start    <= 1'b0;
            r_core_rst <= 1'b0;
            r_seed     <= 7'h7F;
            r_pkt_cnt  <= 16'd0;
            r_err_cnt  <= 8'd0;
            r_rr_ptr   <= 2'd0;
            r_timer    <= 32'd0;
            r_gap_len  <= 16'd0;
        end else begin
            r_state    <= w_state_nx;
            r_grant    <= w_grant_nx;
            r_ack      <= w_ack_nx;
            r_err      <= w_err_nx;
            r_start    <= w_start_nx;
            r_core_rst <= w_core_rst_nx;
            r_seed     <= w_seed_nx;
            r_pkt_cnt  <= w_pkt_cnt_nx;
            r_err_cnt  <= w_err_cnt_nx;
            r_rr_ptr   <= w_rr_ptr_nx;
            r_timer    <= w_timer_nx;
            r_gap_len  <= w_gap_len_nx;
        end
    end

    assign tx_grant              = r_grant;
    assign tx_ack                = r_ack;
    assign tx_err                = r_err;
    assign phy_tx_start          = r_start;
    assign core_rst              = r_core_rst;
    assign init_data_scram_state = r_seed;
    assign pkt_cnt               = r_pkt_cnt;
    assign err_cnt               = r_err_cnt;

endmodule
